// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 8085 ALU op sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Operation kind, resolved once at the handshake.
    typedef enum logic [1:0] {
        K_ALU,
        K_CMP,
        K_INR,
        K_DCR
    } op_kind_t;

    // ALU control word.
    //   op1,op2     : function select 00 sum, 01 AND, 10 XOR, 11 OR
    //   neg         : complement the TMP operand (subtract forms)
    //   ncarry_1    : carry chain takes a carry-in (from CY, or tied to 1 for INR/DCR)
    //   shift_right : rotate path, unused by this sequencer's opcode set
    typedef struct packed {
        logic op1;
        logic op2;
        logic neg;
        logic ncarry_1;
        logic shift_right;
    } cw_t;

    localparam cw_t CW_ADD = cw_t'(5'b00000);
    localparam cw_t CW_ADC = cw_t'(5'b00010);
    localparam cw_t CW_SUB = cw_t'(5'b00110);
    localparam cw_t CW_SBB = cw_t'(5'b00100);
    localparam cw_t CW_ANA = cw_t'(5'b01000);
    localparam cw_t CW_XRA = cw_t'(5'b10000);
    localparam cw_t CW_ORA = cw_t'(5'b11000);
    localparam cw_t CW_CMP = cw_t'(5'b00110);
    // INR/DCR reuse the add-with-carry word; carry is tied to 1 so ACT(00/FE)+r+1 = r+1 / r-1.
    localparam cw_t CW_INC = CW_ADC;

    // Flag masks, bit order {S,Z,AC,P,CY}.
    localparam logic [4:0] FM_ALL  = 5'b11111;
    localparam logic [4:0] FM_NOCY = 5'b11110;

    // Opcode class masks: (opcode & MASK) == VAL.
    localparam logic [7:0] ALU_REG_MASK = 8'hC0;
    localparam logic [7:0] ALU_REG_VAL  = 8'h80;
    localparam logic [7:0] ALU_IMM_MASK = 8'hC7;
    localparam logic [7:0] ALU_IMM_VAL  = 8'hC6;
    localparam logic [7:0] INR_MASK     = 8'hC7;
    localparam logic [7:0] INR_VAL      = 8'h04;
    localparam logic [7:0] DCR_MASK     = 8'hC7;
    localparam logic [7:0] DCR_VAL      = 8'h05;

    function automatic cw_t alu_cw(input logic [2:0] ooo);
        cw_t cw;
        case (ooo)
            3'd0:    cw = CW_ADD;
            3'd1:    cw = CW_ADC;
            3'd2:    cw = CW_SUB;
            3'd3:    cw = CW_SBB;
            3'd4:    cw = CW_ANA;
            3'd5:    cw = CW_XRA;
            3'd6:    cw = CW_ORA;
            default: cw = CW_CMP;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: class, ALU control word and flag mask.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer samples outputs only on its handshake.
// Ports: i_opcode (8085 opcode) -> o_legal, o_kind, o_cw, o_fmask.
// Build option: ALU_SEQ_CMP_EN makes CMP/CPI legal; otherwise they decode as illegal.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic       o_legal,
    output op_kind_t   o_kind,
    output cw_t        o_cw,
    output logic [4:0] o_fmask
);

    logic [2:0] w_ooo;
    assign w_ooo = i_opcode[5:3];

    always_comb begin
        o_legal = 1'b0;
        o_kind  = K_ALU;
        o_cw    = CW_ADD;
        o_fmask = FM_ALL;
        if (((i_opcode & ALU_REG_MASK) == ALU_REG_VAL) ||
            ((i_opcode & ALU_IMM_MASK) == ALU_IMM_VAL)) begin
            o_cw = alu_cw(w_ooo);
            if (w_ooo == 3'd7) begin
                o_kind = K_CMP;
`ifdef ALU_SEQ_CMP_EN
                o_legal = 1'b1;
`else
                o_legal = 1'b0;
`endif
            end else begin
                o_kind  = K_ALU;
                o_legal = 1'b1;
            end
        end else if ((i_opcode & INR_MASK) == INR_VAL) begin
            o_legal = 1'b1;
            o_kind  = K_INR;
            o_cw    = CW_INC;
            o_fmask = FM_NOCY;
        end else if ((i_opcode & DCR_MASK) == DCR_VAL) begin
            o_legal = 1'b1;
            o_kind  = K_DCR;
            o_cw    = CW_INC;
            o_fmask = FM_NOCY;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences 8085 ALU/INR/DCR opcodes through LOAD, EXEC, WRITE, DONE strobes.
// Latency: handshake at edge N -> LOAD N+1, EXEC N+2, WRITE N+3, done N+4, ready N+5.
// Backpressure: op_ready only in IDLE; op_valid/opcode ignored while busy.
// Ports: phi1/rst; op_valid/opcode/op_ready handshake; opnd_req and ACT/TMP load
// strobes; select_* control word; result steering; flag_we/flag_mask; done/illegal.
// Build option: ALU_SEQ_CMP_EN (handled in alu_op_decode) enables CMP/CPI.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic       phi1,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [7:0] opcode,
    output logic       op_ready,
    output logic       opnd_req,
    output logic       a_to_act,
    output logic       sel_0_fe,
    output logic       fe_0_to_act,
    output logic       write_dbus_to_alu_tmp,
    output logic       select_op1,
    output logic       select_op2,
    output logic       select_neg,
    output logic       select_ncarry_1,
    output logic       select_shift_right,
    output logic       alu_to_a,
    output logic       sel_alu_a,
    output logic       alu_a_to_dbus,
    output logic       flag_we,
    output logic [4:0] flag_mask,
    output logic       done,
    output logic       illegal
);

    logic       w_legal;
    op_kind_t   w_kind;
    cw_t        w_cw;
    logic [4:0] w_fmask;

    alu_op_decode u_decode (
        .i_opcode (opcode),
        .o_legal  (w_legal),
        .o_kind   (w_kind),
        .o_cw     (w_cw),
        .o_fmask  (w_fmask)
    );

    state_t     r_state;
    op_kind_t   r_kind;
    cw_t        r_cw;
    logic [4:0] r_fmask;
    cw_t        r_sel;

    // Gated by rst so every output reads 0 while reset is held.
    assign op_ready = (r_state == ST_IDLE) && !rst;

    assign select_op1         = r_sel.op1;
    assign select_op2         = r_sel.op2;
    assign select_neg         = r_sel.neg;
    assign select_ncarry_1    = r_sel.ncarry_1;
    assign select_shift_right = r_sel.shift_right;

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            r_state               <= ST_IDLE;
            r_kind                <= K_ALU;
            r_cw                  <= CW_ADD;
            r_fmask               <= 5'b0;
            r_sel                 <= cw_t'(5'b0);
            opnd_req              <= 1'b0;
            a_to_act              <= 1'b0;
            sel_0_fe              <= 1'b0;
            fe_0_to_act           <= 1'b0;
            write_dbus_to_alu_tmp <= 1'b0;
            alu_to_a              <= 1'b0;
            sel_alu_a             <= 1'b0;
            alu_a_to_dbus         <= 1'b0;
            flag_we               <= 1'b0;
            flag_mask             <= 5'b0;
            done                  <= 1'b0;
            illegal               <= 1'b0;
        end else begin
            // Every strobe is a one-cycle pulse; only the state being entered raises it.
            r_sel                 <= cw_t'(5'b0);
            opnd_req              <= 1'b0;
            a_to_act              <= 1'b0;
            sel_0_fe              <= 1'b0;
            fe_0_to_act           <= 1'b0;
            write_dbus_to_alu_tmp <= 1'b0;
            alu_to_a              <= 1'b0;
            sel_alu_a             <= 1'b0;
            alu_a_to_dbus         <= 1'b0;
            flag_we               <= 1'b0;
            flag_mask             <= 5'b0;
            done                  <= 1'b0;
            illegal               <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_kind  <= w_kind;
                        r_cw    <= w_cw;
                        r_fmask <= w_fmask;
                        if (w_legal) begin
                            r_state               <= ST_LOAD;
                            opnd_req              <= 1'b1;
                            write_dbus_to_alu_tmp <= 1'b1;
                            if (w_kind == K_INR || w_kind == K_DCR) begin
                                sel_0_fe    <= 1'b1;
                                fe_0_to_act <= (w_kind == K_DCR);
                            end else begin
                                a_to_act <= 1'b1;
                            end
                        end else begin
                            // Illegal opcodes borrow DONE for their one pulse, with done held low.
                            r_state <= ST_DONE;
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_EXEC;
                    r_sel   <= r_cw;
                end
                ST_EXEC: begin
                    r_state   <= ST_WRITE;
                    r_sel     <= r_cw;
                    flag_we   <= 1'b1;
                    flag_mask <= r_fmask;
                    case (r_kind)
                        K_ALU:   alu_to_a <= 1'b1;
                        K_INR,
                        K_DCR: begin
                            sel_alu_a     <= 1'b1;
                            alu_a_to_dbus <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_WRITE: begin
                    r_state <= ST_DONE;
                    done    <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
